// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide engine:
// op encodings, sequencer states and the default operand width.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the engine, purely combinational.
// Multiply: acc += opa when opb[0]; opa <<= 1; opb >>= 1.
// Divide (restoring): {rem,quot} <<= 1, trial-subtract divisor (opa low half)
// from rem; keep and set quot LSB when non-negative, else restore.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [2*WIDTH-1:0]   opa_in,
  input  logic [WIDTH-1:0]     opb_in,
  output logic [2*WIDTH-1:0]   acc_out,
  output logic [2*WIDTH-1:0]   opa_out,
  output logic [WIDTH-1:0]     opb_out
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  // Single shift-add or restoring-divide step.
  always_comb begin
    acc_out = acc_in;
    opa_out = opa_in;
    opb_out = opb_in;
    rem_sh  = {acc_in[WIDTH-1:0], opb_in[WIDTH-1]};
    diff    = {1'b0, rem_sh} - {2'b00, opa_in[WIDTH-1:0]};
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        acc_out = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
        opb_out = {opb_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {{WIDTH{1'b0}}, rem_sh[WIDTH-1:0]};
        opb_out = {opb_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (opb_in[0]) acc_out = acc_in + opa_in;
      opa_out = opa_in << 1;
      opb_out = opb_in >> 1;
    end
  end

endmodule

// File: rtl/muldiv_engine.sv
// Iterative MIPS mult/multu/div/divu engine with its own sequencer.
// IDLE -> PREP (abs values, sign flags) -> ITER (WIDTH steps) -> FIX (sign
// correction, HI/LO update, done pulse). Optional build macro
// MULDIV_EARLY_OUT_EN lets multiplies leave ITER once the multiplier is zero.
module muldiv_engine
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   rs_q, rt_q;
  logic [2*WIDTH-1:0] acc_q, opa_q, acc_nx, opa_nx, prod;
  logic [WIDTH-1:0]   opb_q, opb_nx, a_abs, b_abs, hi_fix, lo_fix;
  logic               neg_res_q, neg_rem_q, div0_q;
  logic               is_div, is_signed, last_iter, early_out;

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign a_abs     = is_signed ? abs_w(rs_q) : rs_q;
  assign b_abs     = is_signed ? abs_w(rt_q) : rt_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = ~is_div && (opb_q == '0);
`else
  assign early_out = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_in  (acc_q),
    .opa_in  (opa_q),
    .opb_in  (opb_q),
    .acc_out (acc_nx),
    .opa_out (opa_nx),
    .opb_out (opb_nx)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PREP;
      ST_PREP: state_d = ST_ITER;
      ST_ITER: if (last_iter || early_out) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Iteration counter and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state_q == ST_FIX);
      if (state_q == ST_PREP)      cnt_q <= '0;
      else if (state_q == ST_ITER) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Operand latch, PREP setup and iteration datapath (no reset on data).
  always_ff @(posedge clk) begin
    case (state_q)
      ST_IDLE: if (start) begin
        op_q <= op;
        rs_q <= rs_val;
        rt_q <= rt_val;
      end
      ST_PREP: begin
        acc_q     <= '0;
        opa_q     <= {{WIDTH{1'b0}}, is_div ? b_abs : a_abs};
        opb_q     <= is_div ? a_abs : b_abs;
        neg_res_q <= is_signed & (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
        neg_rem_q <= is_signed & rs_q[WIDTH-1];
        div0_q    <= (rt_q == '0);
      end
      ST_ITER: begin
        acc_q <= acc_nx;
        opa_q <= opa_nx;
        opb_q <= opb_nx;
      end
      default: ;
    endcase
  end

  // Final sign correction and divide-by-zero substitution.
  always_comb begin
    prod   = neg_res_q ? -acc_q : acc_q;
    hi_fix = prod[2*WIDTH-1:WIDTH];
    lo_fix = prod[WIDTH-1:0];
    if (is_div) begin
      if (div0_q) begin
        hi_fix = rs_q;
        lo_fix = '1;
      end else begin
        lo_fix = neg_res_q ? -opb_q : opb_q;
        hi_fix = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
    end
  end

  // HI/LO result registers, loaded only in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (state_q == ST_FIX) begin
      hi_out <= hi_fix;
      lo_out <= lo_fix;
    end
  end

endmodule

// File: doc/muldiv_engine.md
# muldiv_engine

Iterative multi-cycle multiply/divide engine with its own sequencer. It executes MIPS `mult`, `multu`, `div` and `divu` using a radix-2 shift-add / restoring-divide loop, and holds the HI/LO results. It sits beside the multi-cycle CPU controller. The controller pulses `start` when it leaves decode with a mul/div instruction, then holds its final state while `busy` is high. HI/LO register writes take `hi_out`/`lo_out` when `done` pulses.

## Interface

Parameters:
- WIDTH, 32, operand width; also the iteration count.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  launch request; sampled only while idle
- op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start
- rs_val  input  WIDTH  multiplicand / dividend
- rt_val  input  WIDTH  multiplier / divisor
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; results valid in that cycle and held afterwards
- hi_out  output  WIDTH  product[2W-1:W] or remainder
- lo_out  output  WIDTH  product[W-1:0] or quotient

## Operation

- States: IDLE, PREP, ITER, FIX.
  - IDLE→PREP on start; op and operands are latched.
  - PREP→ITER always, with cnt=0.
  - ITER→FIX when cnt=WIDTH-1 completes.
  - FIX→IDLE always.
- PREP:
  - Signed ops (mult, div): take the absolute value of each operand.
  - Record the result sign: the XOR of the operand signs; for div, also the dividend sign for the remainder.
  - Unsigned ops pass the operands through unchanged.
- ITER, multiply:
  - If multiplier bit 0 is set, add the multiplicand (2W wide) into a 2W accumulator.
  - Shift the multiplicand left and the multiplier right.
- ITER, divide (restoring):
  - Shift {rem,quot} left by 1, then trial-subtract the divisor from rem.
  - Non-negative result: keep it and set the quot LSB. Negative result: restore.
- FIX, signed ops only:
  - mult: negate the 2W product if the sign flag is set.
  - div: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
  - hi_out/lo_out update and done is registered high here.
- Divisor zero (div/divu):
  - lo_out=all ones, hi_out=rs_val (original, unmodified).
  - No sign fix; same latency.
- Signed overflow: 0x80000000 / -1 → lo_out=0x80000000, hi_out=0 (natural wrap).
- start while busy: ignored; no effect on state or latched operands.
- start in the same cycle done is high: accepted, because state is IDLE in that cycle.
- Reset: rst overrides everything, including a simultaneous start. Mid-operation it aborts immediately.
- Reset values: busy=0, done=0, hi_out=0, lo_out=0, state=IDLE.

## Timing

- Edge E0 samples start. Busy rises after E0.
- PREP completes at E1. Iterations run at E2..E(WIDTH+1). FIX completes at E(WIDTH+2).
- done is high for exactly one cycle after E(WIDTH+2): E34 for WIDTH=32. busy falls in that same cycle.
- busy is high for WIDTH+2 cycles.
- hi_out/lo_out change only at the FIX edge or on reset.

## Configuration

- MULDIV_EARLY_OUT_EN defined:
  - For mult/multu, an ITER cycle that finds the shifted multiplier register equal to zero goes directly to FIX without iterating.
  - Result: multiply by 0 gives done after E3; multiply by 1 gives done after E4.
  - Divides are unaffected.
- Undefined: every op takes the fixed WIDTH+2 latency.

## Structure

- Package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum: ST_IDLE, ST_PREP, ST_ITER, ST_FIX;
  - the default WIDTH constant.
- Sub-module muldiv_step: purely combinational single iteration. Given mode, accumulator/remainder, multiplicand/divisor and multiplier/quotient, it returns next values.
- muldiv_engine owns the FSM, counter, sign flags, PREP/FIX logic and output registers.

## Test plan

- mult rs=0xFFFFFFFD (-3), rt=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. done exactly 34 cycles after start edge; busy high 34 cycles.
- multu 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 → lo=3, hi=1. div 7/-2 → lo=0xFFFFFFFD, hi=1.
- divu 5/0 → lo=0xFFFFFFFF, hi=5. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Second start pulsed at cycle 5 of an op → ignored, first result unchanged. rst at cycle 10 → busy=0, hi/lo=0 next cycle, no done; a fresh start then completes normally in 34.
- MULDIV_EARLY_OUT_EN: mult 5×0 → done after E3, hi=lo=0. mult 5×1 → done after E4, lo=5. Without the macro both take E34.
